counter_updn: RTL

COUNTER_UPDN -- requirements
Module: counter_updn

---
 rtl/counter_pkg.sv | 21 ++
 rtl/edge_detect.sv | 26 ++
 rtl/counter_updn.sv | 109 ++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter: mode selectors and the per-cycle operation type.
package counter_pkg;

  localparam int unsigned MODE_WRAP  = 0;
  localparam int unsigned MODE_SAT   = 1;
  localparam int unsigned MODE_LEVEL = 0;
  localparam int unsigned MODE_EDGE  = 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_e;

  typedef struct packed {
    logic carry;
    logic borrow;
  } flags_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registers d every cycle and flags d high while its previous sample was low.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  always_comb begin
    d_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/counter_updn.sv
// Up/down counter with load, wrap or saturate at limits, edge or level counting,
// and registered carry/borrow pulses.
module counter_updn
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
  parameter int unsigned      SATURATE  = MODE_WRAP,
  parameter int unsigned      EDGE_MODE = MODE_EDGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_min
);

  localparam bit SAT_EN  = (SATURATE == MODE_SAT);
  localparam bit EDGE_EN = (EDGE_MODE == MODE_EDGE);

  logic [WIDTH-1:0] count_q, count_d;
  flags_t           flags_q, flags_d;
  logic             inc_rise, dec_rise;
  logic             inc_evt, dec_evt;
  op_e              op;

  edge_detect u_inc_edge (
    .clk   (clk),
    .reset (reset),
    .d     (inc),
    .rise  (inc_rise)
  );

  edge_detect u_dec_edge (
    .clk   (clk),
    .reset (reset),
    .d     (dec),
    .rise  (dec_rise)
  );

  // en masks only counting events; the edge history above keeps tracking regardless
  assign inc_evt = en & (EDGE_EN ? inc_rise : inc);
  assign dec_evt = en & (EDGE_EN ? dec_rise : dec);

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (inc_evt && !dec_evt) begin
      op = OP_INC;
    end else if (dec_evt && !inc_evt) begin
      op = OP_DEC;
    end
  end

  always_comb begin
    count_d        = count_q;
    flags_d.carry  = 1'b0;
    flags_d.borrow = 1'b0;
    case (op)
      OP_LOAD: begin
        count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end
      OP_INC: begin
        if (count_q == MAX_VAL) begin
          flags_d.carry = 1'b1;
          count_d       = SAT_EN ? MAX_VAL : '0;
        end else begin
          count_d = WIDTH'(count_q + 1'b1);
        end
      end
      OP_DEC: begin
        if (count_q == '0) begin
          flags_d.borrow = 1'b1;
          count_d        = SAT_EN ? '0 : MAX_VAL;
        end else begin
          count_d = WIDTH'(count_q - 1'b1);
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      flags_q <= '0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign count  = count_q;
  assign carry  = flags_q.carry;
  assign borrow = flags_q.borrow;
  assign at_max = (count_q == MAX_VAL);
  assign at_min = (count_q == '0);

endmodule
